vera_video_timing: RTL and testbench

Raster timing generator that sits directly upstream of the VERA demo renderer. It produces the pixel clock enable, sync and blank strobes, and the current pixel coordinates that the renderer uses to fetch and emit pixels. It supports two raster modes: 640x480 VGA (scandoubled) and 640x240 15 kHz. Mode is selected by `scandouble` and changes only at a frame boundary, so the renderer never sees a torn frame.

---
 rtl/vera_video_timing_if.sv | 24 ++
 rtl/vera_video_timing.sv | 134 +++++++++++++
 tb/tb_vera_video_timing.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vera_video_timing_if.sv
// rtl/vera_video_timing_if.sv - raster timing bundle between the timing generator and the renderer
interface vera_video_timing_if;
    logic       scandouble;
    logic       ce_pix;
    logic       HBlank;
    logic       HSync;
    logic       VBlank;
    logic       VSync;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;
    logic       mode;

    modport master (
        input  scandouble,
        output ce_pix, HBlank, HSync, VBlank, VSync, x, y, line_start, frame_start, mode
    );

    modport slave (
        output scandouble,
        input  ce_pix, HBlank, HSync, VBlank, VSync, x, y, line_start, frame_start, mode
    );
endinterface

// File: rtl/vera_video_timing.sv
// rtl/vera_video_timing.sv - VGA 480p / 15 kHz 240p raster timing generator for the VERA renderer
module vera_video_timing #(
    parameter int CE_DIV          = 4,
    parameter int H_TOTAL         = 800,
    parameter int H_ACTIVE        = 640,
    parameter int HSYNC_START     = 656,
    parameter int HSYNC_END       = 751,
    parameter int VGA_V_TOTAL     = 525,
    parameter int VGA_V_ACTIVE    = 480,
    parameter int VGA_VSYNC_START = 490,
    parameter int VGA_VSYNC_END   = 491,
    parameter int LO_V_TOTAL      = 262,
    parameter int LO_V_ACTIVE     = 240,
    parameter int LO_VSYNC_START  = 243,
    parameter int LO_VSYNC_END    = 245
) (
    input  logic                clk,
    input  logic                reset_n,
    vera_video_timing_if.master vt
);
    localparam int DIV_W = $clog2(2 * CE_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST_VGA = DIV_W'(CE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST_LO  = DIV_W'(2 * CE_DIV - 1);

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT       = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START    = 10'(HSYNC_START);
    localparam logic [9:0] HS_END      = 10'(HSYNC_END);
    localparam logic [9:0] VGA_V_LAST  = 10'(VGA_V_TOTAL - 1);
    localparam logic [9:0] VGA_V_ACT   = 10'(VGA_V_ACTIVE);
    localparam logic [9:0] VGA_VS_START = 10'(VGA_VSYNC_START);
    localparam logic [9:0] VGA_VS_END  = 10'(VGA_VSYNC_END);
    localparam logic [9:0] LO_V_LAST   = 10'(LO_V_TOTAL - 1);
    localparam logic [9:0] LO_V_ACT    = 10'(LO_V_ACTIVE);
    localparam logic [9:0] LO_VS_START = 10'(LO_VSYNC_START);
    localparam logic [9:0] LO_VS_END   = 10'(LO_VSYNC_END);

    logic [DIV_W-1:0] div;
    logic [9:0]       h;
    logic [9:0]       v;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             mode_q;
    logic             mode_next;
    logic             ce_q;
    logic             hblank_q;
    logic             hsync_q;
    logic             vblank_q;
    logic             vsync_q;
    logic             line_start_q;
    logic             frame_start_q;
    logic             div_wrap;
    logic             h_wrap;
    logic             v_wrap;
    logic             vblank_next;
    logic             vsync_next;

    assign div_wrap = (div == (mode_q ? DIV_LAST_VGA : DIV_LAST_LO));
    assign h_wrap   = (h == H_LAST);
    assign v_wrap   = (v == (mode_q ? VGA_V_LAST : LO_V_LAST));

    // Position advances on the edge after the ce_pix pulse, so the pulse always sees a stable pixel.
    always_comb begin
        h_next    = h;
        v_next    = v;
        mode_next = mode_q;
        if (ce_q) begin
            if (h_wrap) begin
                h_next = 10'd0;
                if (v_wrap) begin
                    v_next    = 10'd0;
                    mode_next = vt.scandouble;
                end else begin
                    v_next = v + 10'd1;
                end
            end else begin
                h_next = h + 10'd1;
            end
        end
    end

    // Vertical decode follows the mode of the frame being entered, not the one being left.
    always_comb begin
        vblank_next = 1'b0;
        vsync_next  = 1'b0;
        if (mode_next) begin
            vblank_next = (v_next >= VGA_V_ACT);
            vsync_next  = (v_next >= VGA_VS_START) && (v_next <= VGA_VS_END);
        end else begin
            vblank_next = (v_next >= LO_V_ACT);
            vsync_next  = (v_next >= LO_VS_START) && (v_next <= LO_VS_END);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div           <= '0;
            ce_q          <= 1'b0;
            h             <= 10'd0;
            v             <= 10'd0;
            mode_q        <= 1'b1;
            hblank_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vblank_q      <= 1'b0;
            vsync_q       <= 1'b0;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            div           <= div_wrap ? '0 : div + DIV_W'(1);
            ce_q          <= div_wrap;
            h             <= h_next;
            v             <= v_next;
            mode_q        <= mode_next;
            hblank_q      <= (h_next >= H_ACT);
            hsync_q       <= (h_next >= HS_START) && (h_next <= HS_END);
            vblank_q      <= vblank_next;
            vsync_q       <= vsync_next;
            line_start_q  <= (h_next == 10'd0);
            frame_start_q <= (h_next == 10'd0) && (v_next == 10'd0);
        end
    end

    assign vt.ce_pix      = ce_q;
    assign vt.HBlank      = hblank_q;
    assign vt.HSync       = hsync_q;
    assign vt.VBlank      = vblank_q;
    assign vt.VSync       = vsync_q;
    assign vt.x           = h;
    assign vt.y           = v;
    assign vt.line_start  = line_start_q;
    assign vt.frame_start = frame_start_q;
    assign vt.mode        = mode_q;
endmodule

// File: tb/tb_vera_video_timing.sv
// tb/tb_vera_video_timing.sv - self-checking bench for vera_video_timing
`timescale 1ns/100ps
module tb_vera_video_timing;
    localparam int CE_DIV = 4;
    localparam logic [27:0] RESET_VEC = {1'b0, 4'b0000, 3'b111, 20'd0};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vera_video_timing_if if_a ();
    vera_video_timing_if if_b ();

    vera_video_timing #(.CE_DIV(CE_DIV)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .vt      (if_a)
    );

    // Shrunken raster so whole frames and mode switches fit in a short run.
    vera_video_timing #(
        .CE_DIV(CE_DIV), .H_TOTAL(24), .H_ACTIVE(16), .HSYNC_START(18), .HSYNC_END(20),
        .VGA_V_TOTAL(20), .VGA_V_ACTIVE(14), .VGA_VSYNC_START(16), .VGA_VSYNC_END(17),
        .LO_V_TOTAL(14), .LO_V_ACTIVE(10), .LO_VSYNC_START(11), .LO_VSYNC_END(13)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .vt      (if_b)
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    int     g_ht[2], g_ha[2], g_hs0[2], g_hs1[2];
    int     g_vt[2][2], g_va[2][2], g_vs0[2][2], g_vs1[2][2];
    longint m_t[2];
    bit     m_mode[2];

    // Reference: clocks since the last frame boundary give pixel index and pulse phase directly.
    function automatic int per(int d);
        return m_mode[d] ? CE_DIV : 2 * CE_DIV;
    endfunction

    function automatic logic sd(int d);
        return (d == 0) ? if_a.scandouble : if_b.scandouble;
    endfunction

    function automatic logic [27:0] exp_vec(int d);
        longint idx;
        int     h, v, m;
        logic   ce;
        m   = int'(m_mode[d]);
        idx = (m_t[d] == 0) ? 0 : (m_t[d] - 1) / per(d);
        h   = int'(idx % g_ht[d]);
        v   = int'(idx / g_ht[d]);
        ce  = (m_t[d] > 0) && (m_t[d] % per(d) == 0);
        return {ce, h >= g_ha[d], h >= g_hs0[d] && h <= g_hs1[d],
                v >= g_va[d][m], v >= g_vs0[d][m] && v <= g_vs1[d][m],
                h == 0, h == 0 && v == 0, m_mode[d], 10'(h), 10'(v)};
    endfunction

    function automatic logic [27:0] got_vec(int d);
        if (d == 0)
            return {if_a.ce_pix, if_a.HBlank, if_a.HSync, if_a.VBlank, if_a.VSync,
                    if_a.line_start, if_a.frame_start, if_a.mode, if_a.x, if_a.y};
        return {if_b.ce_pix, if_b.HBlank, if_b.HSync, if_b.VBlank, if_b.VSync,
                if_b.line_start, if_b.frame_start, if_b.mode, if_b.x, if_b.y};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_t[d]    = 0;
            m_mode[d] = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (reset_n) begin
            for (int d = 0; d < 2; d++) begin
                longint p, n;
                p = per(d);
                n = longint'(g_ht[d]) * g_vt[d][int'(m_mode[d])];
                m_t[d]++;
                if ((m_t[d] - 1) / p >= n) begin
                    m_t[d]    = m_t[d] - p * n;
                    m_mode[d] = sd(d);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        if_a.scandouble = 1'b0;
        if_b.scandouble = 1'b0;
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_vec(d) !== RESET_VEC)
                $display("FAIL reset_hold dut%0d got %h expected %h", d, got_vec(d), RESET_VEC);
            else n_pass++;
        end
        if_a.scandouble = 1'b1;
        if_b.scandouble = 1'b1;
        reset_n = 1'b1;
        for (int c = 1; c <= CE_DIV; c++) begin
            step();
            n_checks++;
            if (if_a.ce_pix !== 1'(c == CE_DIV))
                $display("FAIL first_ce edge %0d got %b expected %b", c, if_a.ce_pix, c == CE_DIV);
            else n_pass++;
        end
        n_checks++;
        if ({if_a.x, if_a.y, if_a.frame_start} !== {20'd0, 1'b1})
            $display("FAIL first_pixel got x=%0d y=%0d fs=%b expected x=0 y=0 fs=1",
                     if_a.x, if_a.y, if_a.frame_start);
        else n_pass++;
    endtask

    task automatic test_vga_line();
        bit   bad = 0;
        int   last_ce = -1, pmin = 1 << 30, pmax = 0;
        int   hb_rise = -1, hs_min = 1 << 30, hs_max = -1;
        int   last_line = -1, line_len = -1;
        int   prev_x = -1, prev_y = -1;
        bit   wrap_seen = 0, wrap_ok = 0;
        logic prev_hb = 1'b0;
        for (int c = 0; c < 2 * 800 * CE_DIV + 16; c++) begin
            step();
            for (int d = 0; d < 2 && !bad; d++) begin
                n_checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    $display("FAIL line_model dut%0d cyc %0d got %h expected %h", d, cyc, got_vec(d), exp_vec(d));
                    bad = 1;
                end else n_pass++;
            end
            if (if_a.ce_pix) begin
                if (last_ce >= 0) begin
                    if (cyc - last_ce < pmin) pmin = cyc - last_ce;
                    if (cyc - last_ce > pmax) pmax = cyc - last_ce;
                end
                last_ce = cyc;
                if (if_a.HBlank && !prev_hb && hb_rise < 0) hb_rise = int'(if_a.x);
                prev_hb = if_a.HBlank;
                if (if_a.HSync) begin
                    if (int'(if_a.x) < hs_min) hs_min = int'(if_a.x);
                    if (int'(if_a.x) > hs_max) hs_max = int'(if_a.x);
                end
                if (if_a.x == 10'd0) begin
                    if (last_line >= 0) line_len = cyc - last_line;
                    last_line = cyc;
                end
                if (prev_x == 799 && if_a.x == 10'd0 && !wrap_seen) begin
                    wrap_seen = 1;
                    wrap_ok   = (int'(if_a.y) == prev_y + 1);
                end
                prev_x = int'(if_a.x);
                prev_y = int'(if_a.y);
            end
        end
        n_checks++;
        if (pmin != 4 || pmax != 4) $display("FAIL vga_ce_period got %0d..%0d expected 4", pmin, pmax);
        else n_pass++;
        n_checks++;
        if (hb_rise != 640) $display("FAIL hblank_rise got x=%0d expected 640", hb_rise);
        else n_pass++;
        n_checks++;
        if (hs_min != 656 || hs_max != 751) $display("FAIL hsync_span got %0d..%0d expected 656..751", hs_min, hs_max);
        else n_pass++;
        n_checks++;
        if (line_len != 3200) $display("FAIL line_period got %0d expected 3200", line_len);
        else n_pass++;
        n_checks++;
        if (!wrap_ok) $display("FAIL x_wrap_y_inc got seen=%0d ok=%0d expected 1", wrap_seen, wrap_ok);
        else n_pass++;
    endtask

    task automatic test_vga_frame();
        bit   bad = 0;
        int   vb_first = -1, vs_min = 1 << 30, vs_max = -1;
        int   last_fs = -1, frame_len = -1, prev_y = -1;
        bit   wrap_ok = 0;
        logic prev_vb = 1'b0;
        for (int c = 0; c < 2 * 24 * 20 * CE_DIV + 16; c++) begin
            step();
            for (int d = 0; d < 2 && !bad; d++) begin
                n_checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    $display("FAIL frame_model dut%0d cyc %0d got %h expected %h", d, cyc, got_vec(d), exp_vec(d));
                    bad = 1;
                end else n_pass++;
            end
            if (if_b.ce_pix) begin
                if (if_b.VBlank && !prev_vb && vb_first < 0) vb_first = int'(if_b.y);
                prev_vb = if_b.VBlank;
                if (if_b.VSync) begin
                    if (int'(if_b.y) < vs_min) vs_min = int'(if_b.y);
                    if (int'(if_b.y) > vs_max) vs_max = int'(if_b.y);
                end
                if (prev_y == 19 && if_b.y == 10'd0 && if_b.frame_start) wrap_ok = 1;
                if (if_b.frame_start) begin
                    if (last_fs >= 0) frame_len = cyc - last_fs;
                    last_fs = cyc;
                end
                prev_y = int'(if_b.y);
            end
        end
        n_checks++;
        if (vb_first != 14) $display("FAIL vblank_first got y=%0d expected 14", vb_first);
        else n_pass++;
        n_checks++;
        if (vs_min != 16 || vs_max != 17) $display("FAIL vga_vsync_span got %0d..%0d expected 16..17", vs_min, vs_max);
        else n_pass++;
        n_checks++;
        if (!wrap_ok) $display("FAIL vga_y_wrap got 0 expected 1");
        else n_pass++;
        n_checks++;
        if (frame_len != 1920) $display("FAIL vga_frame_period got %0d expected 1920", frame_len);
        else n_pass++;
    endtask

    task automatic test_mode_switch();
        bit   bad = 0, found = 0, wrapped = 0, pre_ok = 1;
        logic post_mode = 1'b1;
        int   last_ce = -1, pmin = 1 << 30, pmax = 0;
        int   vs_min = 1 << 30, vs_max = -1, ymax = -1;
        for (int c = 0; c < 2 * 1920 && !found; c++) begin
            step();
            if (if_b.ce_pix && if_b.y == 10'd5) found = 1;
        end
        n_checks++;
        if (!found) $display("FAIL switch_wait got timeout expected y=5");
        else n_pass++;
        if_a.scandouble = 1'b0;
        if_b.scandouble = 1'b0;
        for (int c = 0; c < 1920 + 2688 + 64; c++) begin
            step();
            for (int d = 0; d < 2 && !bad; d++) begin
                n_checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    $display("FAIL switch_model dut%0d cyc %0d got %h expected %h", d, cyc, got_vec(d), exp_vec(d));
                    bad = 1;
                end else n_pass++;
            end
            if (if_b.ce_pix) begin
                if (!wrapped) begin
                    if (if_b.frame_start) begin
                        wrapped   = 1;
                        post_mode = if_b.mode;
                        last_ce   = cyc;
                    end else if (if_b.mode !== 1'b1) pre_ok = 0;
                end else begin
                    if (cyc - last_ce < pmin) pmin = cyc - last_ce;
                    if (cyc - last_ce > pmax) pmax = cyc - last_ce;
                    last_ce = cyc;
                    if (if_b.VSync) begin
                        if (int'(if_b.y) < vs_min) vs_min = int'(if_b.y);
                        if (int'(if_b.y) > vs_max) vs_max = int'(if_b.y);
                    end
                    if (int'(if_b.y) > ymax) ymax = int'(if_b.y);
                end
            end
        end
        n_checks++;
        if (!wrapped || !pre_ok) $display("FAIL mode_hold got wrapped=%0d pre_ok=%0d expected 1 1", wrapped, pre_ok);
        else n_pass++;
        n_checks++;
        if (post_mode !== 1'b0) $display("FAIL mode_after_wrap got %b expected 0", post_mode);
        else n_pass++;
        n_checks++;
        if (pmin != 8 || pmax != 8) $display("FAIL lo_ce_period got %0d..%0d expected 8", pmin, pmax);
        else n_pass++;
        n_checks++;
        if (vs_min != 11 || vs_max != 13) $display("FAIL lo_vsync_span got %0d..%0d expected 11..13", vs_min, vs_max);
        else n_pass++;
        n_checks++;
        if (ymax != 13) $display("FAIL lo_y_max got %0d expected 13", ymax);
        else n_pass++;
    endtask

    task automatic test_glitch();
        bit bad = 0, found = 0;
        for (int c = 0; c < 3000 && !found; c++) begin
            step();
            if (if_b.ce_pix && if_b.y == 10'd4) found = 1;
        end
        n_checks++;
        if (!found) $display("FAIL glitch_wait got timeout expected y=4");
        else n_pass++;
        if_b.scandouble = 1'b1;
        repeat (40) step();
        if_b.scandouble = 1'b0;
        found = 0;
        for (int c = 0; c < 3000 && !found; c++) begin
            step();
            for (int d = 0; d < 2 && !bad; d++) begin
                n_checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    $display("FAIL glitch_model dut%0d cyc %0d got %h expected %h", d, cyc, got_vec(d), exp_vec(d));
                    bad = 1;
                end else n_pass++;
            end
            if (if_b.ce_pix && if_b.frame_start) found = 1;
        end
        n_checks++;
        if (!found || if_b.mode !== 1'b0) $display("FAIL glitch_mode got found=%0d mode=%b expected 1 0", found, if_b.mode);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bit bad = 0, found = 0;
        for (int c = 0; c < 4000 && !found; c++) begin
            step();
            if (if_a.ce_pix && if_a.x == 10'd300) found = 1;
        end
        n_checks++;
        if (!found) $display("FAIL areset_wait got timeout expected x=300");
        else n_pass++;
        #2;
        reset_n = 1'b0;
        #0.5;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_vec(d) !== RESET_VEC)
                $display("FAIL areset_immediate dut%0d got %h expected %h", d, got_vec(d), RESET_VEC);
            else n_pass++;
        end
        #0.5;
        reset_n = 1'b1;
        model_reset();
        for (int c = 1; c <= 2500; c++) begin
            step();
            for (int d = 0; d < 2 && !bad; d++) begin
                n_checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    $display("FAIL areset_model dut%0d cyc %0d got %h expected %h", d, cyc, got_vec(d), exp_vec(d));
                    bad = 1;
                end else n_pass++;
            end
            if (c == CE_DIV) begin
                n_checks++;
                if ({if_a.ce_pix, if_a.x, if_a.y} !== {1'b1, 20'd0})
                    $display("FAIL areset_restart got ce=%b x=%0d y=%0d expected 1 0 0", if_a.ce_pix, if_a.x, if_a.y);
                else n_pass++;
            end
        end
    endtask

    initial begin
        g_ht[0] = 800; g_ha[0] = 640; g_hs0[0] = 656; g_hs1[0] = 751;
        g_vt[0][1] = 525; g_va[0][1] = 480; g_vs0[0][1] = 490; g_vs1[0][1] = 491;
        g_vt[0][0] = 262; g_va[0][0] = 240; g_vs0[0][0] = 243; g_vs1[0][0] = 245;
        g_ht[1] = 24; g_ha[1] = 16; g_hs0[1] = 18; g_hs1[1] = 20;
        g_vt[1][1] = 20; g_va[1][1] = 14; g_vs0[1][1] = 16; g_vs1[1][1] = 17;
        g_vt[1][0] = 14; g_va[1][0] = 10; g_vs0[1][0] = 11; g_vs1[1][0] = 13;
        if_a.scandouble = 1'b1;
        if_b.scandouble = 1'b1;
        test_reset();
        test_vga_line();
        test_vga_frame();
        test_mode_switch();
        test_glitch();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
